cpu_datapath: RTL and testbench

Register and bus datapath of the 4-bit SAP computer, directly downstream of the control unit. It consumes the 15 one-hot control lines and implements the program counter, memory address register, 16×8 program memory, instruction register, general registers A–D, adder and output register on a shared 8-bit bus. It returns the opcode nibble and the ALU flags to the control unit.

---
 rtl/cpu_datapath_pkg.sv | 65 ++++++
 rtl/cpu_datapath_program_rom.sv | 26 ++
 rtl/cpu_datapath.sv | 129 ++++++++++++
 tb/tb_cpu_datapath.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_datapath_pkg.sv
// Shared definitions for the SAP datapath: control-line bit positions and
// one-hot masks, opcode values and flag indices.
package cpu_datapath_pkg;

    localparam int unsigned CTL_W  = 15;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned OPC_W  = 4;
    localparam int unsigned FLAG_W = 2;

    // Control-line bit positions
    localparam int unsigned CTL_EP = 0;
    localparam int unsigned CTL_LM = 1;
    localparam int unsigned CTL_C  = 2;
    localparam int unsigned CTL_LI = 3;
    localparam int unsigned CTL_EM = 4;
    localparam int unsigned CTL_LA = 5;
    localparam int unsigned CTL_LB = 6;
    localparam int unsigned CTL_LC = 7;
    localparam int unsigned CTL_LD = 8;
    localparam int unsigned CTL_EI = 9;
    localparam int unsigned CTL_EA = 10;
    localparam int unsigned CTL_EB = 11;
    localparam int unsigned CTL_ES = 12;
    localparam int unsigned CTL_LO = 13;
    localparam int unsigned CTL_LP = 14;

    // One-hot masks
    localparam logic [CTL_W-1:0] CTL_EP_M = CTL_W'(1) << CTL_EP;
    localparam logic [CTL_W-1:0] CTL_LM_M = CTL_W'(1) << CTL_LM;
    localparam logic [CTL_W-1:0] CTL_C_M  = CTL_W'(1) << CTL_C;
    localparam logic [CTL_W-1:0] CTL_LI_M = CTL_W'(1) << CTL_LI;
    localparam logic [CTL_W-1:0] CTL_EM_M = CTL_W'(1) << CTL_EM;
    localparam logic [CTL_W-1:0] CTL_LA_M = CTL_W'(1) << CTL_LA;
    localparam logic [CTL_W-1:0] CTL_LB_M = CTL_W'(1) << CTL_LB;
    localparam logic [CTL_W-1:0] CTL_LC_M = CTL_W'(1) << CTL_LC;
    localparam logic [CTL_W-1:0] CTL_LD_M = CTL_W'(1) << CTL_LD;
    localparam logic [CTL_W-1:0] CTL_EI_M = CTL_W'(1) << CTL_EI;
    localparam logic [CTL_W-1:0] CTL_EA_M = CTL_W'(1) << CTL_EA;
    localparam logic [CTL_W-1:0] CTL_EB_M = CTL_W'(1) << CTL_EB;
    localparam logic [CTL_W-1:0] CTL_ES_M = CTL_W'(1) << CTL_ES;
    localparam logic [CTL_W-1:0] CTL_LO_M = CTL_W'(1) << CTL_LO;
    localparam logic [CTL_W-1:0] CTL_LP_M = CTL_W'(1) << CTL_LP;

    // All lines that drive the shared bus
    localparam logic [CTL_W-1:0] CTL_DRV_M = CTL_EP_M | CTL_EM_M | CTL_EI_M |
                                             CTL_EA_M | CTL_EB_M | CTL_ES_M;

    // Opcodes (IR[7:4])
    localparam logic [OPC_W-1:0] OP_NOP = 4'h0;
    localparam logic [OPC_W-1:0] OP_LDA = 4'h1;
    localparam logic [OPC_W-1:0] OP_LDB = 4'h2;
    localparam logic [OPC_W-1:0] OP_ADD = 4'h3;
    localparam logic [OPC_W-1:0] OP_MOV = 4'h4;
    localparam logic [OPC_W-1:0] OP_JMP = 4'h6;
    localparam logic [OPC_W-1:0] OP_JC  = 4'h7;
    localparam logic [OPC_W-1:0] OP_JZ  = 4'h8;
    localparam logic [OPC_W-1:0] OP_OUT = 4'he;
    localparam logic [OPC_W-1:0] OP_HLT = 4'hf;

    // Flag indices
    localparam int unsigned FLAG_C = 0;
    localparam int unsigned FLAG_Z = 1;

endpackage

// File: rtl/cpu_datapath_program_rom.sv
// Program memory: synchronous write port, asynchronous read port, not reset.
module cpu_datapath_program_rom
    import cpu_datapath_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    // Loader write; independent of reset so programs can be loaded while held
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/cpu_datapath.sv
// SAP register/bus datapath: PC, MAR, program memory, IR, A-D, adder, output.
// Optional bus contention detector enabled by CPU_BUS_CONFLICT_CHECK_EN.
module cpu_datapath
    import cpu_datapath_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CTL_W-1:0]  control_lines,
    output logic [OPC_W-1:0]  reg_ir,
    output logic [FLAG_W-1:0] flag_lines,
    output logic [DATA_W-1:0] bus_out,
    output logic [DATA_W-1:0] out_port,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic              bus_conflict
);

    logic [ADDR_W-1:0] reg_pc;
    logic [ADDR_W-1:0] reg_mar;
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] reg_a;
    logic [DATA_W-1:0] reg_b;
    logic [DATA_W-1:0] reg_c;
    logic [DATA_W-1:0] reg_d;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] bus;
    logic [DATA_W:0]   sum_full;

    cpu_datapath_program_rom #(
        .MEM_DEPTH (MEM_DEPTH)
    ) u_program_rom (
        .clk   (clk),
        .we    (prog_we),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (reg_mar),
        .rdata (mem_rdata)
    );

    assign sum_full = (DATA_W+1)'(reg_a) + (DATA_W+1)'(reg_b);

    // Bus driver select, fixed priority EP > EM > EI > EA > EB > ES
    always_comb begin
        bus = '0;
        if (control_lines[CTL_EP]) begin
            bus = {4'h0, reg_pc};
        end else if (control_lines[CTL_EM]) begin
            bus = mem_rdata;
        end else if (control_lines[CTL_EI]) begin
            bus = {4'h0, ir[3:0]};
        end else if (control_lines[CTL_EA]) begin
            bus = reg_a;
        end else if (control_lines[CTL_EB]) begin
            bus = reg_b;
        end else if (control_lines[CTL_ES]) begin
            bus = sum_full[DATA_W-1:0];
        end
    end

    assign bus_out = bus;
    assign reg_ir  = ir[DATA_W-1:DATA_W-OPC_W];

    // Program counter: jump load has priority over increment
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_pc <= '0;
        end else if (control_lines[CTL_LP]) begin
            reg_pc <= bus[ADDR_W-1:0];
        end else if (control_lines[CTL_C]) begin
            reg_pc <= reg_pc + ADDR_W'(1);
        end
    end

    // Bus-loaded registers; every load samples the pre-edge bus value
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_mar  <= '0;
            ir       <= '0;
            reg_a    <= '0;
            reg_b    <= '0;
            reg_c    <= '0;
            reg_d    <= '0;
            out_port <= '0;
        end else begin
            if (control_lines[CTL_LM]) reg_mar  <= bus[ADDR_W-1:0];
            if (control_lines[CTL_LI]) ir       <= bus;
            if (control_lines[CTL_LA]) reg_a    <= bus;
            if (control_lines[CTL_LB]) reg_b    <= bus;
            if (control_lines[CTL_LC]) reg_c    <= bus;
            if (control_lines[CTL_LD]) reg_d    <= bus;
            if (control_lines[CTL_LO]) out_port <= bus;
        end
    end

    // ALU flags, captured only when the adder drives the bus
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flag_lines <= '0;
        end else if (control_lines[CTL_ES]) begin
            flag_lines[FLAG_C] <= sum_full[DATA_W];
            flag_lines[FLAG_Z] <= (sum_full[DATA_W-1:0] == '0);
        end
    end

    // C and D have no bus driver in this datapath; mark them as intentionally unread
    logic unused_cd;
    assign unused_cd = ^{reg_c, reg_d};

`ifdef CPU_BUS_CONFLICT_CHECK_EN
    logic conflict_q;

    // Sticky flag: two or more bus drivers asserted at a clock edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            conflict_q <= 1'b0;
        end else if ($countones(control_lines & CTL_DRV_M) > 1) begin
            conflict_q <= 1'b1;
        end
    end

    assign bus_conflict = conflict_q;
`else
    assign bus_conflict = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_datapath.sv
// Self-checking bench for cpu_datapath: directed test-plan scenarios followed
// by randomized control/loader traffic against a behavioural model.
module tb_cpu_datapath;
    import cpu_datapath_pkg::*;

    logic        clk;
    logic        rst;
    logic [14:0] control_lines;
    logic [3:0]  reg_ir;
    logic [1:0]  flag_lines;
    logic [7:0]  bus_out;
    logic [7:0]  out_port;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [7:0]  prog_data;
    logic        bus_conflict;

    cpu_datapath #(.MEM_DEPTH(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .control_lines (control_lines),
        .reg_ir        (reg_ir),
        .flag_lines    (flag_lines),
        .bus_out       (bus_out),
        .out_port      (out_port),
        .prog_we       (prog_we),
        .prog_addr     (prog_addr),
        .prog_data     (prog_data),
        .bus_conflict  (bus_conflict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state (plain integers)
    int m_pc, m_mar, m_ir, m_a, m_b, m_c, m_d, m_out, m_carry, m_zero, m_conf;
    int m_mem [16];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 0; m_mar = 0; m_ir = 0; m_a = 0; m_b = 0; m_c = 0; m_d = 0;
        m_out = 0; m_carry = 0; m_zero = 0; m_conf = 0;
    endtask

    function automatic int model_bus(input logic [14:0] c);
        if (c[0])       return m_pc;
        else if (c[4])  return m_mem[m_mar];
        else if (c[9])  return m_ir % 16;
        else if (c[10]) return m_a;
        else if (c[11]) return m_b;
        else if (c[12]) return (m_a + m_b) % 256;
        return 0;
    endfunction

    function automatic int n_drivers(input logic [14:0] c);
        return int'(c[0]) + int'(c[4]) + int'(c[9]) + int'(c[10]) + int'(c[11]) + int'(c[12]);
    endfunction

    task automatic check_all();
        check_eq("pc",       32'(dut.reg_pc),  m_pc);
        check_eq("mar",      32'(dut.reg_mar), m_mar);
        check_eq("ir",       32'(dut.ir),      m_ir);
        check_eq("reg_ir",   32'(reg_ir),      m_ir / 16);
        check_eq("a",        32'(dut.reg_a),   m_a);
        check_eq("b",        32'(dut.reg_b),   m_b);
        check_eq("c",        32'(dut.reg_c),   m_c);
        check_eq("d",        32'(dut.reg_d),   m_d);
        check_eq("out_port", 32'(out_port),    m_out);
        check_eq("flags",    32'(flag_lines),  m_zero * 2 + m_carry);
        check_eq("conflict", 32'(bus_conflict), m_conf);
    endtask

    // One clock: drive at negedge, check bus, advance model at posedge, check state
    task automatic cycle(input logic [14:0] c, input logic we, input logic [3:0] wa,
                         input logic [7:0] wd);
        int bus, sum;
        @(negedge clk);
        control_lines = c; prog_we = we; prog_addr = wa; prog_data = wd;
        #1;
        bus = model_bus(c);
        check_eq("bus_out", 32'(bus_out), bus);
        @(posedge clk);
        if (rst) begin
            sum = m_a + m_b;
            if (c[1])  m_mar = bus % 16;
            if (c[3])  m_ir  = bus;
            if (c[5])  m_a   = bus;
            if (c[6])  m_b   = bus;
            if (c[7])  m_c   = bus;
            if (c[8])  m_d   = bus;
            if (c[13]) m_out = bus;
            if (c[14])     m_pc = bus % 16;
            else if (c[2]) m_pc = (m_pc + 1) % 16;
            if (c[12]) begin
                m_carry = (sum > 255) ? 1 : 0;
                m_zero  = (sum % 256 == 0) ? 1 : 0;
            end
`ifdef CPU_BUS_CONFLICT_CHECK_EN
            if (n_drivers(c) >= 2) m_conf = 1;
`endif
        end
        if (we) m_mem[wa] = int'(wd);
        #1;
        check_all();
    endtask

    // Place a value on the bus via memory at MAR, loading the registers in mask
    task automatic put(input logic [14:0] mask, input logic [7:0] val);
        cycle(15'h0, 1'b1, 4'(m_mar), val);
        cycle(mask | CTL_EM_M, 1'b0, 4'h0, 8'h00);
    endtask

    initial begin
        logic [14:0] rc;
        rst = 1'b0; control_lines = '0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        model_reset();
        for (int i = 0; i < 16; i++) m_mem[i] = 0;

        // Memory load while held in reset
        for (int i = 0; i < 16; i++) cycle(15'h0, 1'b1, 4'(i), 8'($urandom));
        @(negedge clk); rst = 1'b1;

        // Idle after reset
        for (int i = 0; i < 5; i++) cycle(15'h0, 1'b0, 4'h0, 8'h00);
        check_eq("pc_idle", 32'(dut.reg_pc), 0);
        check_eq("bus_idle", 32'(bus_out), 0);

        // LD_A 15 fetch/execute
        cycle(15'h0, 1'b1, 4'h0, 8'h1F);
        cycle(CTL_EP_M | CTL_LM_M, 1'b0, 4'h0, 8'h00);
        check_eq("t0_mar", 32'(dut.reg_mar), 0);
        cycle(CTL_C_M | CTL_LI_M | CTL_EM_M, 1'b0, 4'h0, 8'h00);
        check_eq("t1_ir", 32'(dut.ir), 32'h1F);
        check_eq("t1_reg_ir", 32'(reg_ir), 1);
        check_eq("t1_pc", 32'(dut.reg_pc), 1);
        cycle(CTL_EI_M | CTL_LA_M, 1'b0, 4'h0, 8'h00);
        check_eq("t2_a", 32'(dut.reg_a), 32'h0F);
        cycle(15'h0, 1'b0, 4'h0, 8'h00);

        // Adder with carry, then zero
        put(CTL_LA_M, 8'hF0);
        put(CTL_LB_M, 8'h20);
        cycle(CTL_ES_M | CTL_LA_M, 1'b0, 4'h0, 8'h00);
        check_eq("add_a", 32'(dut.reg_a), 32'h10);
        check_eq("add_flags", 32'(flag_lines), 32'h1);
        put(CTL_LA_M, 8'h00);
        put(CTL_LB_M, 8'h00);
        cycle(CTL_ES_M, 1'b0, 4'h0, 8'h00);
        check_eq("zero_flags", 32'(flag_lines), 32'h2);

        // PC wrap and LP-over-C
        put(CTL_LP_M, 8'h0F);
        check_eq("pc_15", 32'(dut.reg_pc), 15);
        cycle(CTL_C_M, 1'b0, 4'h0, 8'h00);
        check_eq("pc_wrap", 32'(dut.reg_pc), 0);
        put(CTL_LI_M, 8'h37);
        cycle(CTL_C_M | CTL_LP_M | CTL_EI_M, 1'b0, 4'h0, 8'h00);
        check_eq("pc_lp_wins", 32'(dut.reg_pc), 7);

        // Contention: EA wins over EB
        put(CTL_LA_M, 8'h11);
        put(CTL_LB_M, 8'h22);
        cycle(CTL_EA_M | CTL_EB_M | CTL_LO_M, 1'b0, 4'h0, 8'h00);
        check_eq("prio_out", 32'(out_port), 32'h11);
        for (int i = 0; i < 3; i++) cycle(15'h0, 1'b0, 4'h0, 8'h00);

        // Reset mid-T2 with LA pending
        put(CTL_LA_M, 8'h5A);
        cycle(CTL_EP_M | CTL_LM_M, 1'b0, 4'h0, 8'h00);
        cycle(CTL_C_M | CTL_LI_M | CTL_EM_M, 1'b0, 4'h0, 8'h00);
        @(negedge clk);
        control_lines = CTL_EI_M | CTL_LA_M;
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_eq("rst_a_now", 32'(dut.reg_a), 0);
        check_all();
        @(posedge clk); #1;
        check_all();
        @(negedge clk); control_lines = '0; rst = 1'b1;
        for (int i = 0; i < 16; i++)
            check_eq("mem_keep", 32'(dut.u_program_rom.mem[i]), m_mem[i]);
        cycle(CTL_EM_M, 1'b0, 4'h0, 8'h00);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            rc = 15'($urandom) & 15'($urandom);
            cycle(rc, ($urandom_range(0, 3) == 0), 4'($urandom), 8'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
